// File: rtl/alu_sel_pkg.sv
// Select codes, default widths and writeback FSM state type shared by the
// writeback stage and the ALU source muxes.
package alu_sel_pkg;

   localparam int DATA_W = 18;
   localparam int SEL_W  = 4;
   localparam int N_REGS = 8;

   localparam logic [3:0] SEL_NONE     = 4'b0000;
   localparam logic [3:0] SEL_RCOL     = 4'b0011;
   localparam logic [3:0] SEL_RROW     = 4'b0100;
   localparam logic [3:0] SEL_RI       = 4'b0101;
   localparam logic [3:0] SEL_RJ       = 4'b0110;
   localparam logic [3:0] SEL_RTOTAL   = 4'b0111;
   localparam logic [3:0] SEL_RADDRESS = 4'b1000;
   localparam logic [3:0] SEL_RBND     = 4'b1001;
   localparam logic [3:0] SEL_RCOLTEMP = 4'b1010;

   // Bank slot of each register; slot = select code - SEL_RCOL.
   localparam logic [2:0] IDX_RCOL     = 3'd0;
   localparam logic [2:0] IDX_RROW     = 3'd1;
   localparam logic [2:0] IDX_RI       = 3'd2;
   localparam logic [2:0] IDX_RJ       = 3'd3;
   localparam logic [2:0] IDX_RTOTAL   = 3'd4;
   localparam logic [2:0] IDX_RADDRESS = 3'd5;
   localparam logic [2:0] IDX_RBND     = 3'd6;
   localparam logic [2:0] IDX_RCOLTEMP = 3'd7;

   typedef enum logic [0:0] {
      ST_EMPTY   = 1'b0,
      ST_PENDING = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_reg_bank.sv
// Eight-entry bank register file with one decoded write port and one
// increment port; a write to the same slot takes priority over the increment.
module wb_reg_bank #(
   parameter int DATA_W = alu_sel_pkg::DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [2:0]             wr_idx,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   inc_en,
   input  logic [2:0]             inc_idx,
   output logic [7:0][DATA_W-1:0] regs
);

   // Per-slot update: write wins, otherwise increment (wrapping), otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_en && (wr_idx == 3'(i))) begin
               regs[i] <= wr_data;
            end else if (inc_en && (inc_idx == 3'(i))) begin
               regs[i] <= regs[i] + DATA_W'(1);
            end else begin
               regs[i] <= regs[i];
            end
         end
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry pending slot, commit FSM, sticky illegal
// destination flag and increment-drop pulse. Optional macro ALU_WB_BYPASS_EN
// forwards the pending data onto dout_* before it is committed.
module alu_writeback #(
   parameter int DATA_W = alu_sel_pkg::DATA_W,
   parameter int SEL_W  = alu_sel_pkg::SEL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [SEL_W-1:0]  wb_select,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              hold,
   input  logic [SEL_W-1:0]  inc_select,
   output logic [DATA_W-1:0] dout_rcol,
   output logic [DATA_W-1:0] dout_rrow,
   output logic [DATA_W-1:0] dout_ri,
   output logic [DATA_W-1:0] dout_rj,
   output logic [DATA_W-1:0] dout_rtotal,
   output logic [DATA_W-1:0] dout_address,
   output logic [DATA_W-1:0] dout_rbnd,
   output logic [DATA_W-1:0] dout_rcoltemp,
   output logic              wb_busy,
   output logic              wb_err,
   output logic              inc_drop
);

   import alu_sel_pkg::*;

   function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
      return (sel >= SEL_W'(SEL_RCOL)) && (sel <= SEL_W'(SEL_RCOLTEMP));
   endfunction

   function automatic logic [2:0] sel_idx(input logic [SEL_W-1:0] sel);
      logic [SEL_W-1:0] diff;
      diff = sel - SEL_W'(SEL_RCOL);
      return diff[2:0];
   endfunction

   wb_state_e                state_r;
   logic [SEL_W-1:0]         pend_sel_r;
   logic [DATA_W-1:0]        pend_data_r;
   logic                     wb_err_r;
   logic                     inc_drop_r;

   logic                     commit_s;
   logic                     pend_legal_s;
   logic [2:0]               pend_idx_s;
   logic                     inc_legal_s;
   logic [2:0]               inc_idx_s;
   logic                     wr_en_s;
   logic                     collide_s;
   logic [7:0][DATA_W-1:0]   regs_s;
   logic [7:0][DATA_W-1:0]   dout_s;

   assign wb_ready     = (state_r == ST_EMPTY) || !hold;
   assign commit_s     = (state_r == ST_PENDING) && !hold;
   assign pend_legal_s = sel_legal(pend_sel_r);
   assign pend_idx_s   = sel_idx(pend_sel_r);
   assign inc_legal_s  = sel_legal(inc_select);
   assign inc_idx_s    = sel_idx(inc_select);
   assign wr_en_s      = commit_s && pend_legal_s;
   assign collide_s    = wr_en_s && inc_legal_s && (inc_idx_s == pend_idx_s);

   wb_reg_bank #(
      .DATA_W (DATA_W)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_s),
      .wr_idx  (pend_idx_s),
      .wr_data (pend_data_r),
      .inc_en  (inc_legal_s),
      .inc_idx (inc_idx_s),
      .regs    (regs_s)
   );

   // Writeback FSM, pending slot capture and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_EMPTY;
         pend_sel_r  <= '0;
         pend_data_r <= '0;
         wb_err_r    <= 1'b0;
         inc_drop_r  <= 1'b0;
      end else begin
         inc_drop_r <= collide_s;
         if (commit_s && !pend_legal_s) begin
            wb_err_r <= 1'b1;
         end else begin
            wb_err_r <= wb_err_r;
         end
         case (state_r)
            ST_EMPTY: begin
               if (wb_valid) begin
                  pend_sel_r  <= wb_select;
                  pend_data_r <= wb_data;
                  state_r     <= ST_PENDING;
               end else begin
                  state_r     <= ST_EMPTY;
               end
            end
            ST_PENDING: begin
               if (!hold) begin
                  if (wb_valid) begin
                     pend_sel_r  <= wb_select;
                     pend_data_r <= wb_data;
                     state_r     <= ST_PENDING;
                  end else begin
                     state_r     <= ST_EMPTY;
                  end
               end else begin
                  state_r <= ST_PENDING;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
            end
         endcase
      end
   end

`ifdef ALU_WB_BYPASS_EN
   // Forward the uncommitted value to its destination register's output.
   always_comb begin
      dout_s = regs_s;
      if ((state_r == ST_PENDING) && pend_legal_s) begin
         dout_s[pend_idx_s] = pend_data_r;
      end else begin
         dout_s = regs_s;
      end
   end
`else
   assign dout_s = regs_s;
`endif

   assign dout_rcol     = dout_s[IDX_RCOL];
   assign dout_rrow     = dout_s[IDX_RROW];
   assign dout_ri       = dout_s[IDX_RI];
   assign dout_rj       = dout_s[IDX_RJ];
   assign dout_rtotal   = dout_s[IDX_RTOTAL];
   assign dout_address  = dout_s[IDX_RADDRESS];
   assign dout_rbnd     = dout_s[IDX_RBND];
   assign dout_rcoltemp = dout_s[IDX_RCOLTEMP];

   assign wb_busy  = (state_r == ST_PENDING);
   assign wb_err   = wb_err_r;
   assign inc_drop = inc_drop_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed, table-driven bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_select;
   logic [17:0] wb_data;
   logic        hold;
   logic [3:0]  inc_select;
   logic [17:0] dout_rcol, dout_rrow, dout_ri, dout_rj;
   logic [17:0] dout_rtotal, dout_address, dout_rbnd, dout_rcoltemp;
   logic        wb_busy, wb_err, inc_drop;

   int checks = 0;
   int passes = 0;

   alu_writeback dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_select     (wb_select),
      .wb_data       (wb_data),
      .hold          (hold),
      .inc_select    (inc_select),
      .dout_rcol     (dout_rcol),
      .dout_rrow     (dout_rrow),
      .dout_ri       (dout_ri),
      .dout_rj       (dout_rj),
      .dout_rtotal   (dout_rtotal),
      .dout_address  (dout_address),
      .dout_rbnd     (dout_rbnd),
      .dout_rcoltemp (dout_rcoltemp),
      .wb_busy       (wb_busy),
      .wb_err        (wb_err),
      .inc_drop      (inc_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  sel;
      logic [17:0] data;
      logic        hold;
      logic [3:0]  inc;
      logic        ready;   // wb_ready before the edge
      int          idx;     // bank slot checked after the edge
      logic [17:0] val;     // expected value, plain build
      logic [17:0] byp;     // expected value, bypass build
      logic        busy;
      logic        err;
      logic        drop;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(logic v, logic [3:0] s, logic [17:0] d, logic h, logic [3:0] inc,
                               logic rdy, int idx, logic [17:0] val, logic [17:0] byp,
                               logic busy, logic err, logic drop);
      vec_t r;
      r.valid = v; r.sel = s; r.data = d; r.hold = h; r.inc = inc; r.ready = rdy;
      r.idx = idx; r.val = val; r.byp = byp; r.busy = busy; r.err = err; r.drop = drop;
      return r;
   endfunction

   function automatic logic [17:0] dout_of(int i);
      case (i)
         0: return dout_rcol;
         1: return dout_rrow;
         2: return dout_ri;
         3: return dout_rj;
         4: return dout_rtotal;
         5: return dout_address;
         6: return dout_rbnd;
         7: return dout_rcoltemp;
         default: return 18'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s dout[%0d]", tag, i), 32'(dout_of(i)), 32'h0);
      end
      chk({tag, " busy"}, 32'(wb_busy), 32'h0);
      chk({tag, " err"}, 32'(wb_err), 32'h0);
      chk({tag, " drop"}, 32'(inc_drop), 32'h0);
      chk({tag, " ready"}, 32'(wb_ready), 32'h1);
   endtask

   task automatic drive(input logic v, input logic [3:0] s, input logic [17:0] d,
                        input logic h, input logic [3:0] inc);
      wb_valid = v; wb_select = s; wb_data = d; hold = h; inc_select = inc;
   endtask

   logic [17:0] exp_v;

   initial begin
      //             v     sel    data       h     inc   rdy  idx val       byp       busy  err   drop
      tbl[0]  = mk(1'b1, 4'h5, 18'h00012, 1'b0, 4'h0, 1'b1, 2, 18'h00000, 18'h00012, 1'b1, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 2, 18'h00012, 18'h00012, 1'b0, 1'b0, 1'b0);
      tbl[2]  = mk(1'b1, 4'h3, 18'h00001, 1'b0, 4'h0, 1'b1, 0, 18'h00000, 18'h00001, 1'b1, 1'b0, 1'b0);
      tbl[3]  = mk(1'b1, 4'h4, 18'h00002, 1'b0, 4'h0, 1'b1, 0, 18'h00001, 18'h00001, 1'b1, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 1, 18'h00002, 18'h00002, 1'b0, 1'b0, 1'b0);
      tbl[5]  = mk(1'b1, 4'h7, 18'h00777, 1'b0, 4'h0, 1'b1, 4, 18'h00000, 18'h00777, 1'b1, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 4'h0, 18'h00000, 1'b1, 4'h0, 1'b0, 4, 18'h00000, 18'h00777, 1'b1, 1'b0, 1'b0);
      tbl[7]  = mk(1'b1, 4'h3, 18'h03333, 1'b1, 4'h0, 1'b0, 4, 18'h00000, 18'h00777, 1'b1, 1'b0, 1'b0);
      tbl[8]  = mk(1'b0, 4'h0, 18'h00000, 1'b1, 4'h0, 1'b0, 4, 18'h00000, 18'h00777, 1'b1, 1'b0, 1'b0);
      tbl[9]  = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 4, 18'h00777, 18'h00777, 1'b0, 1'b0, 1'b0);
      tbl[10] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 0, 18'h00001, 18'h00001, 1'b0, 1'b0, 1'b0);
      tbl[11] = mk(1'b1, 4'h6, 18'h3FFFF, 1'b0, 4'h0, 1'b1, 3, 18'h00000, 18'h3FFFF, 1'b1, 1'b0, 1'b0);
      tbl[12] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 3, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
      tbl[13] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h6, 1'b1, 3, 18'h00000, 18'h00000, 1'b0, 1'b0, 1'b0);
      tbl[14] = mk(1'b1, 4'h6, 18'h00055, 1'b0, 4'h0, 1'b1, 3, 18'h00000, 18'h00055, 1'b1, 1'b0, 1'b0);
      tbl[15] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h6, 1'b1, 3, 18'h00055, 18'h00055, 1'b0, 1'b0, 1'b1);
      tbl[16] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 3, 18'h00055, 18'h00055, 1'b0, 1'b0, 1'b0);
      tbl[17] = mk(1'b1, 4'h3, 18'h00100, 1'b0, 4'h0, 1'b1, 0, 18'h00001, 18'h00100, 1'b1, 1'b0, 1'b0);
      tbl[18] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h4, 1'b1, 1, 18'h00003, 18'h00003, 1'b0, 1'b0, 1'b0);
      tbl[19] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 0, 18'h00100, 18'h00100, 1'b0, 1'b0, 1'b0);
      tbl[20] = mk(1'b1, 4'h9, 18'h00005, 1'b0, 4'h0, 1'b1, 6, 18'h00000, 18'h00005, 1'b1, 1'b0, 1'b0);
      tbl[21] = mk(1'b0, 4'h0, 18'h00000, 1'b1, 4'h9, 1'b0, 6, 18'h00001, 18'h00005, 1'b1, 1'b0, 1'b0);
      tbl[22] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 6, 18'h00005, 18'h00005, 1'b0, 1'b0, 1'b0);
      tbl[23] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'hF, 1'b1, 6, 18'h00005, 18'h00005, 1'b0, 1'b0, 1'b0);
      tbl[24] = mk(1'b1, 4'hC, 18'h3AAAA, 1'b0, 4'h0, 1'b1, 0, 18'h00100, 18'h00100, 1'b1, 1'b0, 1'b0);
      tbl[25] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 0, 18'h00100, 18'h00100, 1'b0, 1'b1, 1'b0);
      tbl[26] = mk(1'b0, 4'h0, 18'h00000, 1'b0, 4'h0, 1'b1, 6, 18'h00005, 18'h00005, 1'b0, 1'b1, 1'b0);

      rst_n = 1'b0;
      drive(1'b0, 4'h0, 18'h0, 1'b0, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 27; r++) begin
         @(negedge clk);
         drive(tbl[r].valid, tbl[r].sel, tbl[r].data, tbl[r].hold, tbl[r].inc);
         #1;
         chk($sformatf("row%0d ready", r), 32'(wb_ready), 32'(tbl[r].ready));
         @(posedge clk);
         #1;
`ifdef ALU_WB_BYPASS_EN
         exp_v = tbl[r].byp;
`else
         exp_v = tbl[r].val;
`endif
         chk($sformatf("row%0d dout[%0d]", r, tbl[r].idx), 32'(dout_of(tbl[r].idx)), 32'(exp_v));
         chk($sformatf("row%0d busy", r), 32'(wb_busy), 32'(tbl[r].busy));
         chk($sformatf("row%0d err", r), 32'(wb_err), 32'(tbl[r].err));
         chk($sformatf("row%0d drop", r), 32'(inc_drop), 32'(tbl[r].drop));
      end

      // Reset asserted while an entry is pending: everything clears, entry discarded.
      @(negedge clk);
      drive(1'b1, 4'h8, 18'h00888, 1'b0, 4'h0);
      @(posedge clk);
      #1;
      chk("midrst pending busy", 32'(wb_busy), 32'h1);
      @(negedge clk);
      drive(1'b0, 4'h0, 18'h0, 1'b0, 4'h0);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst raddress discarded", 32'(dout_address), 32'h0);
      chk("midrst busy after", 32'(wb_busy), 32'h0);

      // Pending rbnd held by stall: bypass build shows it early, plain build does not.
      @(negedge clk);
      drive(1'b1, 4'h9, 18'h0ABCD, 1'b0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 4'h0, 18'h0, 1'b1, 4'h0);
      #1;
`ifdef ALU_WB_BYPASS_EN
      chk("bypass rbnd early", 32'(dout_rbnd), 32'h0ABCD);
`else
      chk("plain rbnd early", 32'(dout_rbnd), 32'h0);
`endif
      chk("stall busy", 32'(wb_busy), 32'h1);
      chk("stall ready", 32'(wb_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      hold = 1'b0;
      @(posedge clk);
      #1;
      chk("rbnd committed", 32'(dout_rbnd), 32'h0ABCD);
      chk("rbnd busy clear", 32'(wb_busy), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 18: datapath width of the write bus and of every bank register.
REQ-002 Parameter SEL_W, default 4: width of the destination select codes.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wb_valid  input  1  write request present.
REQ-006 wb_ready  output  1  request accepted when wb_valid && wb_ready at the clock edge.
REQ-007 wb_select  input  SEL_W  destination code: 0011 rcol, 0100 rrow, 0101 ri, 0110 rj, 0111 rtotal, 1000 raddress, 1001 rbnd, 1010 rcoltemp.
REQ-008 wb_data  input  DATA_W  ALU result to write.
REQ-009 hold  input  1  controller stall; blocks the commit stage.
REQ-010 inc_select  input  SEL_W  register to increment this cycle, same encoding; 0000 means none.
REQ-011 dout_rcol, dout_rrow, dout_ri, dout_rj, dout_rtotal, dout_address, dout_rbnd, dout_rcoltemp  output  DATA_W each  bank register values, which feed the ALU source muxes.
REQ-012 wb_busy  output  1  pending entry held.
REQ-013 wb_err  output  1  sticky illegal-destination flag.
REQ-014 inc_drop  output  1  one-cycle pulse: increment discarded.

Function
REQ-015 Two states: EMPTY and PENDING; one pending slot holds {select, data}.
REQ-016 wb_ready = (state==EMPTY) || !hold, combinational.
REQ-017 Accept in EMPTY: capture the request; go to PENDING.
REQ-018 Commit: in PENDING with hold=0, write data to the decoded register at that edge.
- Next state is PENDING if a new request is accepted at the same edge, otherwise EMPTY.
REQ-019 Latency: accept at edge N, visible on dout_* after edge N+1 when hold=0; each hold cycle adds one cycle.
REQ-020 Back-to-back accepts with hold=0 sustain one write per cycle with no bubble.
REQ-021 Illegal wb_select (0000, 0001, 0010, 1011-1111): accepted and committed as a no-op; set wb_err at commit.
- wb_err is cleared only by reset.
REQ-022 Increment: a legal inc_select adds 1 to that register at the edge; modulo 2^DATA_W, so 3FFFF wraps to 00000.
- An illegal non-zero inc_select is ignored and does not set wb_err.
REQ-023 Increment and commit to the same register at the same edge: the commit value wins; pulse inc_drop the next cycle.
- Increment and commit to different registers at the same edge: both take effect.
REQ-024 hold does not block increments.
REQ-025 wb_busy = (state==PENDING).

Reset
REQ-026 On rst_n low, immediately:
- all bank registers = 0;
- state = EMPTY;
- wb_err = 0, inc_drop = 0, wb_busy = 0.
REQ-027 A pending entry at reset is discarded, never committed.
REQ-028 Release of rst_n is synchronised by the integrating level; the block needs no internal synchroniser.

Configuration
REQ-029 Macro ALU_WB_BYPASS_EN.
- Defined: each dout_* combinationally shows the pending data while PENDING targets that register; latency becomes 0 cycles after accept.
- Undefined: dout_* are pure register outputs.
- Register state, commit and increment behaviour are identical in both builds.

Structure
REQ-030 Shared package alu_sel_pkg holds the select-code constants shared with the ALU source muxes, plus DATA_W.
REQ-031 Sub-module wb_reg_bank: eight registers with decoded write enable and increment port; alu_writeback holds the FSM, pending slot, error and bypass logic.

Verification
REQ-032 Reset, then wb_select=0101, wb_data=00012, hold=0 -> dout_ri=00012 after two edges; wb_err=0.
REQ-033 Two back-to-back writes (rcol=00001, rrow=00002) with hold=0 -> wb_ready stays 1; both registers are updated on consecutive cycles.
REQ-034 Accept a write, then hold=1 for 3 cycles -> wb_busy=1 and wb_ready=0 throughout; commit on the first edge with hold=0.
REQ-035 rj=3FFFF, inc_select=0110 -> rj=00000; commit rj=00055 with inc_select=0110 at the same edge -> rj=00055 and inc_drop pulses once.
REQ-036 wb_select=1100 -> no register changes and wb_err=1; it stays 1 until rst_n is asserted low mid-pending, after which all outputs are 0.
REQ-037 With ALU_WB_BYPASS_EN: accept rbnd=0ABCD -> dout_rbnd=0ABCD in the cycle after the accepting edge, before the commit.
